// File: rtl/gmii_egress_arbiter.sv
// ---------------------------------------------------------------------------
// gmii_egress_arbiter
//
// Frame-granular round-robin arbiter for one switch egress port. Each ingress
// port presents a GMII stream (data/dv/err) and a destination mask that is
// sampled only on the first byte of a frame (SOF). At most one frame is
// forwarded at a time. The forwarded bytes appear on the egress GMII TX
// exactly one clock after they arrive, and are not modified. A minimum
// inter-frame gap is enforced after each frame.
//
// The block holds no frame buffer. A frame that loses arbitration, or that
// starts while the port is busy, is dropped and counted. A frame that runs
// longer than MAX_FRAME_CYC cycles is cut short: the final forwarded byte is
// marked with tx_er, and the frame is counted as truncated.
//
// Ports
//   clk        in   GMII 125 MHz clock; all logic uses the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_data    in   ingress bytes; port i at [8i+7:8i]
//   in_dv      in   ingress data valid, one bit per port
//   in_err     in   ingress error, one bit per port
//   in_dest    in   destination mask of port i at [PORT_NUMBER*i +: PORT_NUMBER]
//   out_txd    out  egress GMII TXD
//   out_tx_en  out  egress GMII TX_EN
//   out_tx_er  out  egress GMII TX_ER
//   grant      out  one-hot ingress port that owns the egress, 0 when none
//   busy       out  high while a frame is passing, draining, or in the gap
//   drop_cnt   out  saturating count of dropped frames
//   trunc_cnt  out  saturating count of frames truncated by the watchdog
// ---------------------------------------------------------------------------
module gmii_egress_arbiter #(
  parameter int PORT_NUMBER   = 4,
  parameter int EGRESS_INDEX  = 0,
  parameter int IFG_CYCLES    = 12,
  parameter int MAX_FRAME_CYC = 1530,
  parameter int CNT_W         = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PORT_NUMBER*8-1:0]           in_data,
  input  logic [PORT_NUMBER-1:0]             in_dv,
  input  logic [PORT_NUMBER-1:0]             in_err,
  input  logic [PORT_NUMBER*PORT_NUMBER-1:0] in_dest,
  output logic [7:0]                         out_txd,
  output logic                               out_tx_en,
  output logic                               out_tx_er,
  output logic [PORT_NUMBER-1:0]             grant,
  output logic                               busy,
  output logic [CNT_W-1:0]                   drop_cnt,
  output logic [CNT_W-1:0]                   trunc_cnt
);

  localparam int PTR_W = (PORT_NUMBER > 1) ? $clog2(PORT_NUMBER) : 1;
  localparam int FRM_W = $clog2(MAX_FRAME_CYC + 1);
  localparam int IFG_W = $clog2(IFG_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS  = 2'd1,
    S_DRAIN = 2'd2,
    S_IFG   = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] f_popcnt(input logic [PORT_NUMBER-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < PORT_NUMBER; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Adds without wrapping: the result sticks at all-ones.
  function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t                   r_state;
  logic [PORT_NUMBER-1:0]   r_dv_q;
  logic [7:0]               r_txd;
  logic                     r_tx_en;
  logic                     r_tx_er;
  logic [PORT_NUMBER-1:0]   r_grant;
  logic [PTR_W-1:0]         r_rr_ptr;
  logic [FRM_W-1:0]         r_frm_cnt;
  logic [IFG_W-1:0]         r_ifg_cnt;
  logic [CNT_W-1:0]         r_drop_cnt;
  logic [CNT_W-1:0]         r_trunc_cnt;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic [7:0]               w_dat [PORT_NUMBER];
  logic [PORT_NUMBER-1:0]   w_req;
  logic                     w_win_found;
  logic [PTR_W-1:0]         w_win_idx;
  logic [PTR_W-1:0]         w_cand;
  logic [PTR_W-1:0]         w_sel;
  logic [7:0]               w_sel_data;
  logic                     w_sel_dv;
  logic                     w_sel_err;
  logic [CNT_W-1:0]         w_req_cnt;
  logic [CNT_W-1:0]         w_drop_inc;
  logic [CNT_W-1:0]         w_trunc_inc;
  state_t                   w_nxt_state;
  logic [7:0]               w_nxt_txd;
  logic                     w_nxt_tx_en;
  logic                     w_nxt_tx_er;
  logic [PORT_NUMBER-1:0]   w_nxt_grant;
  logic [PTR_W-1:0]         w_nxt_rr_ptr;
  logic [FRM_W-1:0]         w_nxt_frm_cnt;
  logic [IFG_W-1:0]         w_nxt_ifg_cnt;

  // Only the EGRESS_INDEX column of each destination mask matters here.
  logic                     w_unused_dest;
  assign w_unused_dest = ^in_dest;

  // -------------------------------------------------------------------------
  // Request detection: a port requests only on the SOF cycle of a frame that
  // is addressed to this egress, and never for its own port (no hairpin).
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < PORT_NUMBER; g++) begin : g_port
    assign w_dat[g] = in_data[8*g +: 8];
    if (g == EGRESS_INDEX) begin : g_hairpin
      assign w_req[g] = 1'b0;
    end else begin : g_other
      assign w_req[g] = in_dv[g] & ~r_dv_q[g] & in_dest[PORT_NUMBER*g + EGRESS_INDEX];
    end
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = r_rr_ptr;
    w_cand      = r_rr_ptr;
    for (int k = 1; k <= PORT_NUMBER; k++) begin
      w_cand = PTR_W'((int'(r_rr_ptr) + k) % PORT_NUMBER);
      if (!w_win_found && w_req[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  // The port whose stream feeds the output: the fresh winner in IDLE, else
  // the port granted last (rr_ptr always holds the latest winner).
  assign w_sel      = (r_state == S_IDLE) ? w_win_idx : r_rr_ptr;
  assign w_sel_data = w_dat[w_sel];
  assign w_sel_dv   = in_dv[w_sel];
  assign w_sel_err  = in_err[w_sel];

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_txd     = 8'h00;
    w_nxt_tx_en   = 1'b0;
    w_nxt_tx_er   = 1'b0;
    w_nxt_grant   = r_grant;
    w_nxt_rr_ptr  = r_rr_ptr;
    w_nxt_frm_cnt = r_frm_cnt;
    w_nxt_ifg_cnt = r_ifg_cnt;
    w_trunc_inc   = '0;
    w_req_cnt     = f_popcnt(w_req);
    // Outside IDLE every request is a frame that cannot be carried.
    w_drop_inc    = w_req_cnt;

    case (r_state)
      S_IDLE: begin
        w_drop_inc = '0;
        if (w_win_found) begin
          // Every requester except the winner loses this round.
          w_drop_inc    = w_req_cnt - CNT_W'(1);
          w_nxt_state   = S_PASS;
          w_nxt_grant   = PORT_NUMBER'(1) << w_win_idx;
          w_nxt_rr_ptr  = w_win_idx;
          w_nxt_frm_cnt = FRM_W'(1);
          w_nxt_txd     = w_sel_data;
          w_nxt_tx_en   = 1'b1;
          w_nxt_tx_er   = w_sel_err;
        end
      end

      S_PASS: begin
        if (!w_sel_dv) begin
          w_nxt_grant   = '0;
          w_nxt_ifg_cnt = IFG_W'(1);
          w_nxt_state   = S_IFG;
        end else if (r_frm_cnt == FRM_W'(MAX_FRAME_CYC - 1)) begin
          // This byte is the MAX_FRAME_CYC-th one on the wire: send it
          // flagged as errored so the far end discards the frame.
          w_nxt_txd     = w_sel_data;
          w_nxt_tx_en   = 1'b1;
          w_nxt_tx_er   = 1'b1;
          w_trunc_inc   = CNT_W'(1);
          w_nxt_state   = S_DRAIN;
        end else begin
          w_nxt_txd     = w_sel_data;
          w_nxt_tx_en   = 1'b1;
          w_nxt_tx_er   = w_sel_err;
          w_nxt_frm_cnt = r_frm_cnt + FRM_W'(1);
        end
      end

      S_DRAIN: begin
        // Swallow the rest of the over-long frame.
        if (!w_sel_dv) begin
          w_nxt_grant   = '0;
          w_nxt_ifg_cnt = IFG_W'(1);
          w_nxt_state   = S_IFG;
        end
      end

      S_IFG: begin
        if (r_ifg_cnt == IFG_W'(IFG_CYCLES)) begin
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_ifg_cnt = r_ifg_cnt + IFG_W'(1);
        end
      end

      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_grant = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // -------------------------------------------------------------------------
  // Output, pointer and counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // dv history starts at all-ones so that a frame already in flight when
      // reset is released does not look like a fresh SOF.
      r_dv_q      <= '1;
      r_txd       <= 8'h00;
      r_tx_en     <= 1'b0;
      r_tx_er     <= 1'b0;
      r_grant     <= '0;
      r_rr_ptr    <= PTR_W'(PORT_NUMBER - 1);
      r_frm_cnt   <= '0;
      r_ifg_cnt   <= '0;
      r_drop_cnt  <= '0;
      r_trunc_cnt <= '0;
    end else begin
      r_dv_q      <= in_dv;
      r_txd       <= w_nxt_txd;
      r_tx_en     <= w_nxt_tx_en;
      r_tx_er     <= w_nxt_tx_er;
      r_grant     <= w_nxt_grant;
      r_rr_ptr    <= w_nxt_rr_ptr;
      r_frm_cnt   <= w_nxt_frm_cnt;
      r_ifg_cnt   <= w_nxt_ifg_cnt;
      r_drop_cnt  <= f_sat_add(r_drop_cnt, w_drop_inc);
      r_trunc_cnt <= f_sat_add(r_trunc_cnt, w_trunc_inc);
    end
  end

  assign out_txd   = r_txd;
  assign out_tx_en = r_tx_en;
  assign out_tx_er = r_tx_er;
  assign grant     = r_grant;
  assign busy      = (r_state != S_IDLE);
  assign drop_cnt  = r_drop_cnt;
  assign trunc_cnt = r_trunc_cnt;

endmodule

// File: tb/tb_gmii_egress_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gmii_egress_arbiter
//
// Scoreboard bench for gmii_egress_arbiter (4 ports, egress 0, IFG 12,
// watchdog 100 cycles). Stimulus tasks push the bytes expected on the egress
// into a queue; an independent monitor pops one entry for every cycle with
// out_tx_en high and compares byte, tx_er and grant. It also checks the idle
// gap between forwarded frames. Counters and status are checked directly at
// fixed points in the directed sequence.
// ---------------------------------------------------------------------------
module tb_gmii_egress_arbiter;

  localparam int PN   = 4;
  localparam int EG   = 0;
  localparam int IFG  = 12;
  localparam int MAXC = 100;
  localparam int CW   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [PN*8-1:0]   in_data = '0;
  logic [PN-1:0]     in_dv = '0;
  logic [PN-1:0]     in_err = '0;
  logic [PN*PN-1:0]  in_dest = '0;
  logic [7:0]        out_txd;
  logic              out_tx_en;
  logic              out_tx_er;
  logic [PN-1:0]     grant;
  logic              busy;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     trunc_cnt;

  typedef struct packed {
    logic [7:0]    txd;
    logic          er;
    logic [PN-1:0] gnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  gmii_egress_arbiter #(
    .PORT_NUMBER   (PN),
    .EGRESS_INDEX  (EG),
    .IFG_CYCLES    (IFG),
    .MAX_FRAME_CYC (MAXC),
    .CNT_W         (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_dv     (in_dv),
    .in_err    (in_err),
    .in_dest   (in_dest),
    .out_txd   (out_txd),
    .out_tx_en (out_tx_en),
    .out_tx_er (out_tx_er),
    .grant     (grant),
    .busy      (busy),
    .drop_cnt  (drop_cnt),
    .trunc_cnt (trunc_cnt)
  );

  always #4 clk = ~clk;

  function automatic logic [7:0] bval(input int p, input int j, input int seed);
    return 8'(p * 37 + j * 5 + seed);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drive one frame of len bytes on every port in 'ports' at the same time.
  // The destination mask is only meaningful on the SOF byte; it is inverted
  // afterwards to show that mid-frame mask changes have no effect.
  // win < 0 means no output is expected. err_at < 0 means no in_err.
  task automatic send(input logic [PN-1:0] ports, input logic [PN*PN-1:0] dests,
                      input int len, input int win, input int seed, input int err_at);
    if (win >= 0) begin
      for (int j = 0; j < len && j < MAXC; j++) begin
        exp_t e;
        e.txd = bval(win, j, seed);
        e.er  = (j == MAXC - 1) || (j == err_at);
        e.gnt = PN'(1 << win);
        sb.push_back(e);
      end
    end
    for (int j = 0; j < len; j++) begin
      @(posedge clk);
      #1;
      for (int p = 0; p < PN; p++) begin
        if (ports[p]) begin
          in_dv[p]          = 1'b1;
          in_err[p]         = (j == err_at);
          in_data[8*p +: 8] = bval(p, j, seed);
          in_dest[PN*p +: PN] = (j == 0) ? dests[PN*p +: PN] : ~dests[PN*p +: PN];
        end
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < PN; p++) begin
      if (ports[p]) begin
        in_dv[p]            = 1'b0;
        in_err[p]           = 1'b0;
        in_data[8*p +: 8]   = 8'h00;
        in_dest[PN*p +: PN] = '0;
      end
    end
  endtask

  // Monitor: every transmitted byte must match the head of the scoreboard.
  initial begin : p_mon
    int   low_run;
    bit   seen;
    exp_t e;
    low_run = 1000;
    seen    = 1'b0;
    forever begin
      @(negedge clk);
      if (out_tx_en === 1'b1) begin
        if (seen && low_run > 0) begin
          chk("ifg_gap_ge_12", 32'(low_run >= IFG), 32'd1);
        end
        low_run = 0;
        seen    = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tx actual txd=0x%0h grant=0x%0h required=no output",
                   out_txd, grant);
        end else begin
          e = sb.pop_front();
          chk("sb_txd_er_grant", 32'({out_txd, out_tx_er, grant}), 32'(e));
        end
      end else begin
        low_run++;
      end
    end
  end

  initial begin : p_timeout
    #400000;
    failures++;
    $display("FAIL timeout actual=still running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : p_main
    // Reset state
    #2;
    chk("rst_tx_en", 32'(out_tx_en), 32'd0);
    chk("rst_txd",   32'(out_txd),   32'd0);
    chk("rst_grant", 32'(grant),     32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_drop",  32'(drop_cnt),  32'd0);
    chk("rst_trunc", 32'(trunc_cnt), 32'd0);
    do_reset();
    wait_cyc(3);

    // 1. Single 64-byte frame from port 1
    send(4'b0010, {4{4'b0001}}, 64, 1, 0, -1);
    chk("t1_busy_at_end",  32'(busy),  32'd1);
    chk("t1_grant_at_end", 32'(grant), 32'h2);
    wait_cyc(20);
    chk("t1_busy_after", 32'(busy),     32'd0);
    chk("t1_grant_after", 32'(grant),   32'd0);
    chk("t1_drop",        32'(drop_cnt), 32'd0);

    // 2. Simultaneous SOF on ports 1,2,3: round robin 1 -> 2 -> 3
    do_reset();
    wait_cyc(2);
    send(4'b1110, {4{4'b0001}}, 16, 1, 10, -1);
    wait_cyc(20);
    chk("t2_drop_a", 32'(drop_cnt), 32'd2);
    send(4'b1110, {4{4'b0001}}, 16, 2, 20, -1);
    wait_cyc(20);
    chk("t2_drop_b", 32'(drop_cnt), 32'd4);
    send(4'b1110, {4{4'b0001}}, 16, 3, 30, -1);
    wait_cyc(20);
    chk("t2_drop_c", 32'(drop_cnt), 32'd6);

    // 3. Back-to-back: SOF 5 cycles into the gap and in the last gap cycle are
    //    dropped; SOF one cycle later is forwarded.
    send(4'b0010, {4{4'b0001}}, 16, 1, 40, -1);
    wait_cyc(4);
    send(4'b0100, {4{4'b0001}}, 4, -1, 41, -1);
    wait_cyc(30);
    chk("t3_drop_early", 32'(drop_cnt), 32'd7);
    send(4'b0010, {4{4'b0001}}, 16, 1, 42, -1);
    wait_cyc(11);
    send(4'b0100, {4{4'b0001}}, 4, -1, 43, -1);
    wait_cyc(30);
    chk("t3_drop_last_ifg", 32'(drop_cnt), 32'd8);
    send(4'b0010, {4{4'b0001}}, 16, 1, 44, -1);
    wait_cyc(12);
    send(4'b0100, {4{4'b0001}}, 16, 2, 45, -1);
    wait_cyc(20);
    chk("t3_drop_fwd", 32'(drop_cnt), 32'd8);

    // 4. Watchdog: 150-cycle frame cut at 100 bytes, last with tx_er
    send(4'b1000, {4{4'b0001}}, 150, 3, 50, -1);
    chk("t4_drain_busy",  32'(busy),      32'd1);
    chk("t4_drain_quiet", 32'(out_tx_en), 32'd0);
    chk("t4_trunc",       32'(trunc_cnt), 32'd1);
    wait_cyc(20);
    chk("t4_idle_busy", 32'(busy), 32'd0);

    // 5. Hairpin (port0 -> 0) and frame not addressed here (port2 -> 2)
    send(4'b0101, {4'h0, 4'h4, 4'h0, 4'h1}, 8, -1, 55, -1);
    wait_cyc(20);
    chk("t5_drop_unchanged", 32'(drop_cnt), 32'd8);
    chk("t5_busy",           32'(busy),     32'd0);

    // in_err passthrough without ending the frame
    send(4'b0100, {4{4'b0001}}, 20, 2, 57, 7);
    wait_cyc(20);
    chk("err_drop", 32'(drop_cnt), 32'd8);

    // 6. Asynchronous reset mid-frame
    fork
      send(4'b0010, {4{4'b0001}}, 64, 1, 60, -1);
      begin
        repeat (30) @(posedge clk);
        #1;
        chk("t6_pre_rst_en",  32'(out_tx_en), 32'd1);
        chk("t6_pre_rst_txd", 32'(out_txd),   32'(bval(1, 28, 60)));
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_tx_en", 32'(out_tx_en), 32'd0);
        chk("t6_rst_tx_er", 32'(out_tx_er), 32'd0);
        chk("t6_rst_txd",   32'(out_txd),   32'd0);
        chk("t6_rst_grant", 32'(grant),     32'd0);
        chk("t6_rst_drop",  32'(drop_cnt),  32'd0);
        chk("t6_rst_trunc", 32'(trunc_cnt), 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    wait_cyc(20);
    chk("t6_ignored_busy", 32'(busy),     32'd0);
    chk("t6_ignored_drop", 32'(drop_cnt), 32'd0);
    send(4'b0010, {4{4'b0001}}, 16, 1, 70, -1);
    wait_cyc(20);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
